// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for a UART receiver.
// Buffers received bytes (with their parity-error flag) in a show-ahead FIFO,
// flags dropped bytes with a sticky overflow bit, raises a one-cycle idle
// interrupt when queued data sits unread, and supplies the baud divider.
// Optional autobaud measurement is compiled in when UART_RX_AUTOBAUD_EN is
// defined; without it the divider is simply cfg_clk_div and rx is unused.
module uart_rx_ctrl #(
    parameter int CLK_DIV_WIDTH = 8,
    parameter int FIFO_AW       = 3,
    parameter int TMO_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     enable,
    input  logic [CLK_DIV_WIDTH-1:0] cfg_clk_div,
    output logic [CLK_DIV_WIDTH-1:0] clk_div_out,
    input  logic                     rx,
    input  logic                     rx_re,
    input  logic                     rx_error,
    input  logic                     rx_busy,
    input  logic [7:0]               rx_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     empty,
    output logic                     full,
    output logic [FIFO_AW:0]         count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    input  logic [TMO_WIDTH-1:0]     tmo_cycles,
    output logic                     idle_irq
`ifdef UART_RX_AUTOBAUD_EN
    ,
    input  logic                     ab_start,
    output logic                     ab_done,
    output logic                     ab_valid
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    // FIFO storage: {parity error, data byte}
    logic [8:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_overflow;
    logic [TMO_WIDTH-1:0] r_idle_cnt;
    logic                 r_idle_irq;

    logic                 w_ab_idle;
    logic                 w_wr_req;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_ovf_evt;
    logic [FIFO_AW:0]     w_count_next;
    logic [8:0]           w_head;
    logic                 w_idle_inc;
    logic [TMO_WIDTH-1:0] w_idle_cnt_inc;

    assign empty    = (r_count == '0);
    assign full     = (r_count == FULL_CNT);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign idle_irq = r_idle_irq;

    // A pop only happens when there is something to pop; a write into a full
    // FIFO is allowed only when the same cycle frees a slot.
    assign w_wr_req  = rx_re && enable && w_ab_idle;
    assign w_rd      = rd_en && !empty;
    assign w_wr      = w_wr_req && (!full || w_rd);
    assign w_ovf_evt = w_wr_req && full && !w_rd;

    // Show-ahead head entry; forced to zero while nothing is queued
    assign w_head  = empty ? 9'd0 : r_mem[r_rd_ptr];
    assign rd_err  = w_head[8];
    assign rd_data = w_head[7:0];

    // Occupancy update from the accepted write/read pair
    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + (FIFO_AW + 1)'(1);
            2'b01:   w_count_next = r_count - (FIFO_AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO array write port (no reset so it can map onto RAM)
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {rx_error, rx_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at 2**FIFO_AW
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            r_count <= w_count_next;
        end
    end

    // Sticky overflow; a fresh drop outranks a clear in the same cycle
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Idle counter runs only while data waits and the line is quiet; it stops
    // at tmo_cycles so the interrupt fires once per idle period.
    assign w_idle_inc     = !rx_busy && !empty && (tmo_cycles != '0) && (r_idle_cnt < tmo_cycles);
    assign w_idle_cnt_inc = r_idle_cnt + TMO_WIDTH'(1);

    // Idle counter and one-cycle timeout pulse
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_idle_cnt <= '0;
            r_idle_irq <= 1'b0;
        end else if (rx_re || rx_busy) begin
            r_idle_cnt <= '0;
            r_idle_irq <= 1'b0;
        end else if (w_idle_inc) begin
            r_idle_cnt <= w_idle_cnt_inc;
            r_idle_irq <= (w_idle_cnt_inc == tmo_cycles);
        end else begin
            r_idle_irq <= 1'b0;
        end
    end

`ifdef UART_RX_AUTOBAUD_EN

    typedef enum logic [1:0] {
        AB_IDLE     = 2'd0,
        AB_WAIT_LOW = 2'd1,
        AB_MEASURE  = 2'd2
    } ab_state_t;

    ab_state_t                r_ab_state;
    ab_state_t                w_ab_state_next;
    logic                     w_ab_accept;
    logic                     r_rx_s1;
    logic                     r_rx_s2;
    logic [CLK_DIV_WIDTH-1:0] r_ab_cnt;
    logic [CLK_DIV_WIDTH-1:0] r_ab_div;
    logic                     r_ab_valid;
    logic                     r_ab_done;

    assign w_ab_idle   = (r_ab_state == AB_IDLE);
    assign ab_done     = r_ab_done;
    assign ab_valid    = r_ab_valid;
    assign clk_div_out = r_ab_valid ? r_ab_div : cfg_clk_div;

    // Two-flop synchroniser for the raw serial line (idles high)
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // Autobaud state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ab_state <= AB_IDLE;
        end else begin
            r_ab_state <= w_ab_state_next;
        end
    end

    // Autobaud next state; a low pulse shorter than 2 cycles is a glitch
    always_comb begin
        w_ab_state_next = r_ab_state;
        w_ab_accept     = 1'b0;
        case (r_ab_state)
            AB_IDLE: begin
                if (ab_start) w_ab_state_next = AB_WAIT_LOW;
            end
            AB_WAIT_LOW: begin
                if (!r_rx_s2) w_ab_state_next = AB_MEASURE;
            end
            AB_MEASURE: begin
                if (r_rx_s2) begin
                    if (r_ab_cnt >= CLK_DIV_WIDTH'(2)) begin
                        w_ab_accept     = 1'b1;
                        w_ab_state_next = AB_IDLE;
                    end else begin
                        w_ab_state_next = AB_WAIT_LOW;
                    end
                end
            end
            default: w_ab_state_next = AB_IDLE;
        endcase
    end

    // Low-time counter: the falling-edge cycle counts as 1, saturates at all ones
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ab_cnt <= '0;
        end else if (r_ab_state == AB_WAIT_LOW && !r_rx_s2) begin
            r_ab_cnt <= CLK_DIV_WIDTH'(1);
        end else if (r_ab_state == AB_MEASURE && !r_rx_s2 && r_ab_cnt != '1) begin
            r_ab_cnt <= r_ab_cnt + CLK_DIV_WIDTH'(1);
        end
    end

    // Latched divider, valid flag and done pulse
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ab_div   <= '0;
            r_ab_valid <= 1'b0;
            r_ab_done  <= 1'b0;
        end else begin
            r_ab_done <= w_ab_accept;
            if (ab_start) begin
                r_ab_valid <= 1'b0;
            end else if (w_ab_accept) begin
                r_ab_valid <= 1'b1;
                r_ab_div   <= r_ab_cnt;
            end
        end
    end

`else

    logic w_unused_rx;

    assign w_ab_idle   = 1'b1;
    assign clk_div_out = cfg_clk_div;
    assign w_unused_rx = rx;

`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model of the FIFO.
// Autobaud scenario is included when UART_RX_AUTOBAUD_EN is defined.
module tb_uart_rx_ctrl;

    localparam int CDW   = 8;
    localparam int AW    = 3;
    localparam int TW    = 16;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           resetb;
    logic           enable;
    logic [CDW-1:0] cfg_clk_div;
    logic [CDW-1:0] clk_div_out;
    logic           rx;
    logic           rx_re;
    logic           rx_error;
    logic           rx_busy;
    logic [7:0]     rx_data;
    logic           rd_en;
    logic [7:0]     rd_data;
    logic           rd_err;
    logic           empty;
    logic           full;
    logic [AW:0]    count;
    logic           overflow;
    logic           overflow_clr;
    logic [TW-1:0]  tmo_cycles;
    logic           idle_irq;
`ifdef UART_RX_AUTOBAUD_EN
    logic           ab_start;
    logic           ab_done;
    logic           ab_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_ctrl #(.CLK_DIV_WIDTH(CDW), .FIFO_AW(AW), .TMO_WIDTH(TW)) dut (
        .clk(clk), .resetb(resetb), .enable(enable),
        .cfg_clk_div(cfg_clk_div), .clk_div_out(clk_div_out),
        .rx(rx), .rx_re(rx_re), .rx_error(rx_error), .rx_busy(rx_busy), .rx_data(rx_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .empty(empty), .full(full), .count(count),
        .overflow(overflow), .overflow_clr(overflow_clr),
        .tmo_cycles(tmo_cycles), .idle_irq(idle_irq)
`ifdef UART_RX_AUTOBAUD_EN
        , .ab_start(ab_start), .ab_done(ab_done), .ab_valid(ab_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_re = 1'b1; rx_data = d; rx_error = e;
        tick();
        rx_re = 1'b0; rx_error = 1'b0;
        $display("push data=%02h err=%0d -> count=%0d", d, e, count);
    endtask

    task automatic pop;
        logic [7:0] d;
        d = rd_data;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("pop  data=%02h -> count=%0d", d, count);
    endtask

    task automatic drain;
        for (int i = 0; i < 2 * DEPTH && !empty; i++) pop();
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        repeat (3) tick();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_cmp++; if (idle_irq !== 1'b0) begin n_bad++; $display("FAIL reset_idle_irq: got %0b expected 0", idle_irq); end
        n_cmp++; if ({rd_err, rd_data} !== 9'd0) begin n_bad++; $display("FAIL reset_rd: got %03h expected 000", {rd_err, rd_data}); end
        n_cmp++; if (clk_div_out !== cfg_clk_div) begin n_bad++; $display("FAIL reset_clk_div: got %0d expected %0d", clk_div_out, cfg_clk_div); end
        resetb = 1'b1;
        tick();
        push(8'hA5, 1'b0);
        push(8'h5A, 1'b0);
        n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL midreset_pre_count: got %0d expected 2", count); end
        #3 resetb = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL midreset_async: got count=%0d empty=%0b expected 0/1", count, empty); end
        #2 resetb = 1'b1;
        tick();
        n_cmp++; if (count !== 4'd0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL midreset_after: got count=%0d rd_data=%02h expected 0/00", count, rd_data); end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL basic_count: got %0d expected 3", count); end
        n_cmp++; if (rd_data !== 8'h11) begin n_bad++; $display("FAIL basic_head0: got %02h expected 11", rd_data); end
        pop();
        n_cmp++; if (rd_data !== 8'h22) begin n_bad++; $display("FAIL basic_head1: got %02h expected 22", rd_data); end
        pop();
        n_cmp++; if (rd_data !== 8'h33) begin n_bad++; $display("FAIL basic_head2: got %02h expected 33", rd_data); end
        pop();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty: got %0b expected 1", empty); end
        pop();
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL basic_pop_empty: got count=%0d expected 0", count); end
        $display("test_basic done");
    endtask

    task automatic test_overflow;
        logic [7:0] b [9];
        for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) push(b[i], 1'b0);
        n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_fill8: got full=%0b ovf=%0b expected 1/0", full, overflow); end
        push(b[8], 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
        n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_bad++; $display("FAIL ovf_count: got %0d expected 8", count); end
        n_cmp++; if (rd_data !== b[0]) begin n_bad++; $display("FAIL ovf_head: got %02h expected %02h", rd_data, b[0]); end
        // Clear and new drop in the same cycle: drop wins
        overflow_clr = 1'b1; rx_re = 1'b1; rx_data = 8'hEE;
        tick();
        overflow_clr = 1'b0; rx_re = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_clr_priority: got %0b expected 1", overflow); end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rd_data !== b[i]) begin n_bad++; $display("FAIL ovf_contents[%0d]: got %02h expected %02h", i, rd_data, b[i]); end
            pop();
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got empty=%0b expected 1", empty); end
        $display("test_overflow done");
    endtask

    task automatic test_full_rw;
        logic [7:0] b [9];
        for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) push(b[i], 1'b0);
        rx_re = 1'b1; rx_data = b[8]; rd_en = 1'b1;
        tick();
        rx_re = 1'b0; rd_en = 1'b0;
        $display("push+pop while full data=%02h -> count=%0d", b[8], count);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fullrw_count: got %0d expected 8", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullrw_overflow: got %0b expected 0", overflow); end
        for (int i = 1; i < 9; i++) begin
            n_cmp++; if (rd_data !== b[i]) begin n_bad++; $display("FAIL fullrw_order[%0d]: got %02h expected %02h", i, rd_data, b[i]); end
            pop();
        end
        $display("test_full_rw done");
    endtask

    task automatic test_idle;
        int pulses;
        drain();
        rx_busy = 1'b0;
        tmo_cycles = 16'd10;
        pulses = 0;
        push(8'($urandom), 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (idle_irq === 1'b1) pulses++;
            n_cmp++; if (idle_irq !== 1'(k == 10)) begin n_bad++; $display("FAIL idle_pulse_k%0d: got %0b expected %0b", k, idle_irq, (k == 10)); end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL idle_pulse_count: got %0d expected 1", pulses); end
        drain();
        tmo_cycles = 16'd0;
        pulses = 0;
        push(8'($urandom), 1'b0);
        repeat (20) begin
            tick();
            if (idle_irq !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL idle_disabled: got %0d pulses expected 0", pulses); end
        drain();
        $display("test_idle done");
    endtask

    task automatic test_err;
        logic [7:0] d0, d1;
        d0 = 8'($urandom); d1 = 8'($urandom);
        push(d0, 1'b1);
        push(d1, 1'b0);
        n_cmp++; if (rd_err !== 1'b1 || rd_data !== d0) begin n_bad++; $display("FAIL err_head: got err=%0b data=%02h expected 1/%02h", rd_err, rd_data, d0); end
        pop();
        n_cmp++; if (rd_err !== 1'b0 || rd_data !== d1) begin n_bad++; $display("FAIL err_next: got err=%0b data=%02h expected 0/%02h", rd_err, rd_data, d1); end
        pop();
        $display("test_err done");
    endtask

    task automatic test_random;
        logic [8:0] q [$];
        logic       m_ovf;
        logic       m_rd, m_req, m_acc;
        drain();
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            enable       = ($urandom_range(0, 9) != 0);
            rx_re        = ($urandom_range(0, 1) == 1);
            rx_data      = 8'($urandom);
            rx_error     = ($urandom_range(0, 3) == 0);
            rd_en        = ($urandom_range(0, 9) < 4);
            overflow_clr = ($urandom_range(0, 19) == 0);
            cfg_clk_div  = CDW'($urandom);
            m_rd  = rd_en && (q.size() > 0);
            m_req = rx_re && enable;
            m_acc = m_req && (q.size() < DEPTH || m_rd);
            if (m_req && q.size() == DEPTH && !m_rd) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (m_rd) void'(q.pop_front());
            if (m_acc) q.push_back({rx_error, rx_data});
            tick();
            if (m_rd || m_req) $display("rand cyc=%0d wr=%0b rd=%0b -> count=%0d", c, m_acc, m_rd, count);
            n_cmp++; if (count !== (AW + 1)'(q.size())) begin n_bad++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, count, q.size()); end
            n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rand_flags c%0d: got e=%0b f=%0b expected size %0d", c, empty, full, q.size()); end
            n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rand_overflow c%0d: got %0b expected %0b", c, overflow, m_ovf); end
            n_cmp++; if (clk_div_out !== cfg_clk_div) begin n_bad++; $display("FAIL rand_clk_div c%0d: got %0d expected %0d", c, clk_div_out, cfg_clk_div); end
            if (q.size() > 0) begin
                n_cmp++; if ({rd_err, rd_data} !== q[0]) begin n_bad++; $display("FAIL rand_head c%0d: got %03h expected %03h", c, {rd_err, rd_data}, q[0]); end
            end
        end
        enable = 1'b1; rx_re = 1'b0; rx_error = 1'b0; rd_en = 1'b0; overflow_clr = 1'b0;
        drain();
        $display("test_random done");
    endtask

`ifdef UART_RX_AUTOBAUD_EN
    task automatic test_autobaud;
        logic seen;
        drain();
        cfg_clk_div = 8'd17;
        ab_start = 1'b1; tick(); ab_start = 1'b0;
        rx = 1'b0;
        repeat (52) tick();
        rx = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            tick();
            if (ab_done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL ab_done_timeout: got no pulse expected pulse within 20 cycles"); end
        n_cmp++; if (clk_div_out !== 8'd52) begin n_bad++; $display("FAIL ab_div: got %0d expected 52", clk_div_out); end
        n_cmp++; if (ab_valid !== 1'b1) begin n_bad++; $display("FAIL ab_valid_set: got %0b expected 1", ab_valid); end
        tick();
        n_cmp++; if (ab_done !== 1'b0) begin n_bad++; $display("FAIL ab_done_pulse: got %0b expected 0", ab_done); end
        ab_start = 1'b1; tick(); ab_start = 1'b0;
        n_cmp++; if (ab_valid !== 1'b0 || clk_div_out !== 8'd17) begin n_bad++; $display("FAIL ab_start_clear: got valid=%0b div=%0d expected 0/17", ab_valid, clk_div_out); end
        repeat (5) tick();
        rx = 1'b0; tick(); rx = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (ab_done !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0 || ab_valid !== 1'b0) begin n_bad++; $display("FAIL ab_glitch: got done=%0b valid=%0b expected 0/0", seen, ab_valid); end
        push(8'h77, 1'b0);
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL ab_suppress_write: got %0d expected 0", count); end
        resetb = 1'b0; tick(); resetb = 1'b1; tick();
        push(8'h78, 1'b0);
        n_cmp++; if (count !== 4'd1 || rd_data !== 8'h78) begin n_bad++; $display("FAIL ab_after_reset: got count=%0d data=%02h expected 1/78", count, rd_data); end
        drain();
        $display("test_autobaud done");
    endtask
`endif

    initial begin
        resetb = 1'b0; enable = 1'b1; cfg_clk_div = 8'd33; rx = 1'b1;
        rx_re = 1'b0; rx_error = 1'b0; rx_busy = 1'b0; rx_data = 8'h00;
        rd_en = 1'b0; overflow_clr = 1'b0; tmo_cycles = 16'd0;
`ifdef UART_RX_AUTOBAUD_EN
        ab_start = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_err();
        test_idle();
        test_random();
`ifdef UART_RX_AUTOBAUD_EN
        test_autobaud();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 8, width of the baud divider.
REQ-002 SHALL have parameter FIFO_AW, default 3, FIFO address width; depth = 2**FIFO_AW entries.
REQ-003 SHALL have parameter TMO_WIDTH, default 16, idle-timeout counter width.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  accept received bytes into the FIFO when high.
REQ-007 SHALL have port cfg_clk_div  input  CLK_DIV_WIDTH  software baud divider.
REQ-008 SHALL have port clk_div_out  output  CLK_DIV_WIDTH  divider driven to the receiver.
REQ-009 SHALL have port rx  input  1  raw serial line, used for autobaud only.
REQ-010 SHALL have port rx_re, rx_error, rx_busy  input  1 each  receiver byte strobe, parity error and busy.
REQ-011 SHALL have port rx_data  input  8  received byte, valid with rx_re.
REQ-012 SHALL have port rd_en  input  1  pop the FIFO head.
REQ-013 SHALL have port rd_data  output  8  FIFO head byte, show-ahead.
REQ-014 SHALL have port rd_err  output  1  parity error flag stored with the head byte.
REQ-015 SHALL have port empty, full  output  1 each  FIFO status.
REQ-016 SHALL have port count  output  FIFO_AW+1  FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky: a byte was dropped.
REQ-018 SHALL have port overflow_clr  input  1  clears overflow.
REQ-019 SHALL have port tmo_cycles  input  TMO_WIDTH  idle timeout in clk cycles; 0 disables.
REQ-020 SHALL have port idle_irq  output  1  one-cycle pulse on idle timeout.

Function
REQ-021 SHALL write {rx_error, rx_data} into the FIFO in the cycle after rx_re=1 when enable=1 and the autobaud FSM is idle.
REQ-022 SHALL present the head entry on rd_data/rd_err whenever empty=0; rd_en pops it, and the next entry appears on the following cycle.
REQ-023 SHALL ignore rd_en while empty=1; count is never decremented below 0.
REQ-024 SHALL accept a write when full=1 only if rd_en=1 in the same cycle; count is then unchanged.
REQ-025 SHALL drop a write while full=1 without rd_en, and set overflow; FIFO contents are unchanged.
REQ-026 SHALL clear overflow on overflow_clr; a simultaneous new overflow event takes priority and keeps overflow=1.
REQ-027 SHALL wrap read and write pointers modulo 2**FIFO_AW; full means count == 2**FIFO_AW.
REQ-028 SHALL clear the idle counter on rx_re or rx_busy, and increment it while rx_busy=0, empty=0 and tmo_cycles!=0.
REQ-029 SHALL pulse idle_irq for one cycle when the idle counter equals tmo_cycles, then hold the counter until the next clear; at most one pulse per idle period.
REQ-030 SHALL drive clk_div_out = cfg_clk_div combinationally unless an autobaud result is active (REQ-034).

Reset
REQ-031 SHALL on resetb=0 set count=0, empty=1, full=0, overflow=0, idle_irq=0, pointers=0, idle counter=0, FSM=AB_IDLE; rd_data/rd_err=0.
REQ-032 SHALL, when reset asserts mid-operation, discard FIFO contents and any autobaud measurement in progress.

Configuration
REQ-033 SHALL compile autobaud logic only when UART_RX_AUTOBAUD_EN is defined; without it, no ab_* ports exist, clk_div_out = cfg_clk_div, and rx is unused.
REQ-034 SHALL with UART_RX_AUTOBAUD_EN add ports ab_start (input 1), ab_done (output 1 pulse) and ab_valid (output 1); rx is double-synchronised; FSM AB_IDLE -> (ab_start) AB_WAIT_LOW -> (synced rx falls) AB_MEASURE, counting cycles while low -> (synced rx rises) AB_IDLE.
REQ-035 SHALL on leaving AB_MEASURE latch the low-time count, saturated to all ones, as the divider, set ab_valid=1, pulse ab_done; counts < 2 are rejected and the FSM returns to AB_WAIT_LOW.
REQ-036 SHALL drive clk_div_out from the latched value while ab_valid=1; ab_valid resets to 0, and ab_start clears it.
REQ-037 SHALL suppress FIFO writes while the FSM is not AB_IDLE.

Verification
REQ-038 SHALL write 3 bytes 0x11, 0x22, 0x33 with rd_en=0 -> count=3, rd_data=0x11; three rd_en pops yield 0x22, 0x33, then empty=1.
REQ-039 SHALL write 9 bytes with FIFO_AW=3 and no reads -> full=1, overflow=1, and the head through the 8th byte are unchanged; overflow_clr -> overflow=0.
REQ-040 SHALL write and read in the same cycle while full -> count stays 8 and overflow stays 0.
REQ-041 SHALL use tmo_cycles=10 with one byte queued and rx_busy=0 -> exactly one idle_irq pulse, 10 cycles after rx_re; with tmo_cycles=0 -> no pulse.
REQ-042 SHALL write a byte with rx_error=1 -> rd_err=1 while that byte is at the head.
REQ-043 SHALL, with UART_RX_AUTOBAUD_EN, use ab_start then rx low for 52 cycles -> ab_done pulse, clk_div_out=52; a 1-cycle glitch is rejected, and ab_valid stays 0.
